// File: rtl/prog_instruction_memory_pkg.sv
// Shared definitions for the run-time loadable instruction memory.
//   imem_state_e  : controller state (no program / loading / running)
//   IMEM_NOP_WORD : default word returned on faulting fetches
//   word_idx()    : byte address -> instruction word index
package imem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } imem_state_e;

  localparam logic [63:0] IMEM_NOP_WORD = 64'h0;

  // Instructions are 4-byte aligned; the two low address bits are only
  // used for the alignment check, never for indexing.
  function automatic logic [63:0] word_idx(input logic [63:0] byte_addr);
    return {2'b00, byte_addr[63:2]};
  endfunction

endpackage

// File: rtl/prog_instruction_memory_if.sv
// Load-stream and fetch bus of the instruction memory.
//   load_*  : valid/ready program load stream (+ start pulse, last, overflow)
//   prog_len: length of the current valid program in words
//   fetch_* : request/address in, 1-cycle registered response out
// master = program loader / fetch stage, slave = the memory.
interface prog_instruction_memory_if #(
  parameter int WIDTH  = 22,
  parameter int ADDR_W = 22,
  parameter int LEN_W  = 8
);
  logic              load_start;
  logic              load_valid;
  logic [WIDTH-1:0]  load_data;
  logic              load_last;
  logic              load_ready;
  logic              load_ovf;
  logic [LEN_W-1:0]  prog_len;
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_valid;
  logic [WIDTH-1:0]  fetch_data;
  logic              fetch_fault;

  modport master (
    output load_start, load_valid, load_data, load_last, fetch_req, fetch_addr,
    input  load_ready, load_ovf, prog_len, fetch_valid, fetch_data, fetch_fault
  );

  modport slave (
    input  load_start, load_valid, load_data, load_last, fetch_req, fetch_addr,
    output load_ready, load_ovf, prog_len, fetch_valid, fetch_data, fetch_fault
  );
endinterface

// File: rtl/prog_instruction_memory_imem_array.sv
// Simple dual-port RAM, WIDTH x DEPTH.
//   i_clk            : clock
//   i_we/i_waddr/i_wdata : synchronous write port
//   i_re/i_raddr     : read enable / address
//   o_rdata          : registered read data, holds when i_re is low
// Contents are deliberately not reset.
module imem_array #(
  parameter int WIDTH = 22,
  parameter int DEPTH = 128,
  parameter int AW    = 7
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_re,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);
  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge i_clk) begin
    if (i_re) o_rdata <= r_mem[i_raddr];
  end
endmodule

// File: rtl/prog_instruction_memory.sv
// Run-time loadable instruction memory for the fetch stage.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : slave side of prog_instruction_memory_if
//           - load stream fills RAM from word 0 after a load_start pulse
//           - fetches return the word one cycle later, or NOP_WORD with
//             fetch_fault when misaligned / out of program / no program.
module prog_instruction_memory
  import imem_pkg::*;
#(
  parameter int               WIDTH    = 22,
  parameter int               DEPTH    = 128,
  parameter int               ADDR_W   = 22,
  parameter logic [WIDTH-1:0] NOP_WORD = IMEM_NOP_WORD[WIDTH-1:0]
) (
  input logic                     clk,
  input logic                     rst_n,
  prog_instruction_memory_if.slave bus
);
  localparam int LEN_W = $clog2(DEPTH + 1);
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  imem_state_e      r_state, w_state_nxt;
  logic [LEN_W-1:0] r_ptr, r_len;
  logic             r_ovf;
  logic             r_fv, r_ff, r_nop_sel;
  logic             w_ready, w_hs, w_ptr_end, w_fault;
  logic [63:0]      w_idx;
  logic [WIDTH-1:0] w_rdata;

  assign w_hs      = bus.load_valid && w_ready;
  assign w_ptr_end = (r_ptr == LEN_W'(DEPTH - 1));
  assign w_idx     = word_idx(64'(bus.fetch_addr));

  // A fetch in the same cycle as load_start is treated as having no program.
  assign w_fault = (r_state != ST_RUN) || bus.load_start ||
                   (bus.fetch_addr[1:0] != 2'b00) || (w_idx >= 64'(r_len));

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_RUN: if (bus.load_start) w_state_nxt = ST_LOAD;
      ST_LOAD: begin
        if (bus.load_start)                       w_state_nxt = ST_LOAD;
        else if (w_hs && (bus.load_last || w_ptr_end)) w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    w_ready = 1'b0;
    if (r_state == ST_LOAD && !bus.load_start) w_ready = 1'b1;
  end

  // ---------------- load pointer / length / overflow ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr <= '0;
      r_len <= '0;
      r_ovf <= 1'b0;
    end else if (bus.load_start) begin
      r_ptr <= '0;
      r_len <= '0;
      r_ovf <= 1'b0;
    end else if (w_hs) begin
      r_ptr <= r_ptr + LEN_W'(1);
      if (bus.load_last) begin
        r_len <= r_ptr + LEN_W'(1);
      end else if (w_ptr_end) begin
        r_len <= LEN_W'(DEPTH);
        r_ovf <= 1'b1;
      end
    end
  end

  // ---------------- fetch response ----------------
  // r_nop_sel selects NOP_WORD vs RAM output; it resets to 1 so fetch_data
  // shows NOP_WORD out of reset although the RAM register is unreset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fv      <= 1'b0;
      r_ff      <= 1'b0;
      r_nop_sel <= 1'b1;
    end else begin
      r_fv <= bus.fetch_req;
      if (bus.fetch_req) begin
        r_ff      <= w_fault;
        r_nop_sel <= w_fault;
      end
    end
  end

  // Read only for non-faulting fetches: the index is then below prog_len,
  // hence inside the array, and the RAM output holds between fetches.
  imem_array #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_array (
    .i_clk   (clk),
    .i_we    (w_hs),
    .i_waddr (r_ptr[AW-1:0]),
    .i_wdata (bus.load_data),
    .i_re    (bus.fetch_req && !w_fault),
    .i_raddr (w_idx[AW-1:0]),
    .o_rdata (w_rdata)
  );

  assign bus.load_ready  = w_ready;
  assign bus.load_ovf    = r_ovf;
  assign bus.prog_len    = r_len;
  assign bus.fetch_valid = r_fv;
  assign bus.fetch_fault = r_ff;
  assign bus.fetch_data  = r_nop_sel ? NOP_WORD : w_rdata;
endmodule

// File: tb/tb_prog_instruction_memory.sv
module tb_prog_instruction_memory;
  localparam int W     = 22;
  localparam int AWID  = 22;
  localparam int DEPTH = 4;
  localparam int LEN_W = $clog2(DEPTH + 1);
  localparam logic [W-1:0] NOP = '0;

  typedef struct {
    bit         vld;
    bit         fault;
    logic [W-1:0] data;
    int         len;
    bit         ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  prog_instruction_memory_if #(.WIDTH(W), .ADDR_W(AWID), .LEN_W(LEN_W)) bus ();

  prog_instruction_memory #(.WIDTH(W), .DEPTH(DEPTH), .ADDR_W(AWID), .NOP_WORD(NOP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int checks = 0;
  int failures = 0;
  bit mon_on = 0;
  int acc_cnt = 0;
  exp_t exp_q[$];
  exp_t me;

  // reference model: the program is simply the list of accepted words
  logic [W-1:0] m_prog[$];
  bit m_load = 0, m_run = 0, m_ovf = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // one clock cycle with the inputs currently on the bus
  task automatic step();
    exp_t e;
    int unsigned idx;
    #1;
    if (mon_on) chk("load_ready", bus.load_ready, m_load && !bus.load_start);
    if (rst_n && bus.load_valid && bus.load_ready) acc_cnt++;
    idx     = int'(bus.fetch_addr >> 2);
    e.vld   = rst_n && bus.fetch_req;
    e.fault = !m_run || bus.load_start || (bus.fetch_addr[1:0] != 2'b00) ||
              (idx >= m_prog.size());
    e.data  = NOP;
    if (!e.fault) e.data = m_prog[idx];
    if (!rst_n) begin
      m_prog.delete(); m_load = 0; m_run = 0; m_ovf = 0;
    end else if (bus.load_start) begin
      m_prog.delete(); m_load = 1; m_run = 0; m_ovf = 0;
    end else if (m_load && bus.load_valid) begin
      m_prog.push_back(bus.load_data);
      if (bus.load_last) begin
        m_load = 0; m_run = 1;
      end else if (m_prog.size() == DEPTH) begin
        m_load = 0; m_run = 1; m_ovf = 1;
      end
    end
    e.len = m_run ? m_prog.size() : 0;
    e.ovf = m_ovf;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input bit rs, input bit st, input bit v, input logic [W-1:0] d,
                     input bit l, input bit rq, input logic [AWID-1:0] a);
    rst_n          = rs;
    bus.load_start = st;
    bus.load_valid = v;
    bus.load_data  = d;
    bus.load_last  = l;
    bus.fetch_req  = rq;
    bus.fetch_addr = a;
    step();
  endtask

  task automatic fetch(input logic [AWID-1:0] a);
    cyc(1, 0, 0, '0, 0, 1, a);
  endtask

  task automatic idle();
    cyc(1, 0, 0, '0, 0, 0, '0);
  endtask

  // monitor: one expectation per cycle, popped after the edge it belongs to
  always @(negedge clk) begin
    if (mon_on) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL scoreboard_empty actual=0 entries expected=1 at %0t", $time);
      end else begin
        me = exp_q.pop_front();
        chk("fetch_valid", bus.fetch_valid, me.vld);
        if (me.vld) begin
          chk("fetch_fault", bus.fetch_fault, me.fault);
          chk("fetch_data", bus.fetch_data, me.data);
        end
        chk("prog_len", 64'(bus.prog_len), 64'(me.len));
        chk("load_ovf", bus.load_ovf, me.ovf);
      end
    end
  end

  initial begin
    // reset
    cyc(0, 0, 0, '0, 0, 0, '0);
    mon_on = 1;
    cyc(0, 0, 0, '0, 0, 1, '0);
    chk("rst_fetch_data", bus.fetch_data, NOP);
    chk("rst_fetch_fault", bus.fetch_fault, 1'b0);

    // fetch with no program
    fetch(22'h0);
    idle();

    // 3-word program
    cyc(1, 1, 0, '0, 0, 0, '0);
    cyc(1, 0, 1, 22'h268088, 0, 0, '0);
    cyc(1, 0, 1, 22'h268088, 0, 0, '0);
    cyc(1, 0, 1, 22'h268109, 1, 0, '0);
    fetch(22'h0); fetch(22'h4); fetch(22'h8);
    fetch(22'hC); fetch(22'h6);
    idle();

    // overflow: 6 words streamed into a 4-deep memory, no last
    acc_cnt = 0;
    cyc(1, 1, 0, '0, 0, 0, '0);
    for (int i = 0; i < 6; i++) cyc(1, 0, 1, W'($urandom), 0, 0, '0);
    idle();
    chk("ovf_accepted", acc_cnt, 4);
    fetch(22'h0); fetch(22'h4); fetch(22'h8); fetch(22'hC); fetch(22'h10);

    // stall then restart; the word presented with load_start is dropped
    cyc(1, 1, 0, '0, 0, 0, '0);
    cyc(1, 0, 1, 22'h0000AA, 0, 0, '0);
    idle(); idle();
    cyc(1, 1, 1, 22'h0003FF, 0, 0, '0);
    cyc(1, 0, 1, 22'h000001, 0, 0, '0);
    cyc(1, 0, 1, 22'h000002, 1, 0, '0);
    fetch(22'h0); fetch(22'h4); fetch(22'h8);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [AWID-1:0] a;
      a = AWID'($urandom_range(0, 7) * 4);
      if ($urandom_range(0, 3) == 0) a = a + AWID'($urandom_range(1, 3));
      cyc(($urandom_range(0, 63) != 0), ($urandom_range(0, 15) == 0),
          ($urandom_range(0, 1) == 1), W'($urandom), ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 9) < 7), a);
    end

    // reset in the middle of a load
    cyc(1, 1, 0, '0, 0, 0, '0);
    cyc(1, 0, 1, 22'h00ABCD, 0, 0, '0);
    cyc(0, 0, 1, 22'h00BEEF, 0, 1, '0);
    fetch(22'h0);
    fetch(22'h4);
    idle();

    #10;
    mon_on = 0;
    chk("scoreboard_drain", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/prog_instruction_memory.md
# prog_instruction_memory

Parametrised, run-time loadable instruction memory for the processor fetch stage. Replaces a hard-wired program image with a RAM filled over a valid/ready load stream, and serves byte-addressed, word-aligned fetches with one-cycle registered latency. Fetches that are misaligned, outside the loaded program, or issued while no valid program exists return a NOP word and raise a fault flag. The control unit uses that flag to trap instead of executing garbage.

## Interface
- `WIDTH`, default 22: instruction word width in bits.
- `DEPTH`, default 128: number of instruction words; must be at least 2.
- `ADDR_W`, default 22: fetch address width. Addresses are byte addresses; the word index is `addr[ADDR_W-1:2]`.
- `NOP_WORD`, default 0: word returned on any faulting fetch.
- `clk`, in, 1: sole clock, rising edge.
- `rst_n`, in, 1: synchronous, active-low reset.
- `load_start`, in, 1: single-cycle pulse that begins a new program load at word 0.
- `load_valid`, in, 1: `load_data` holds a valid word.
- `load_data`, in, `WIDTH`: program word.
- `load_last`, in, 1: the current word is the final program word.
- `load_ready`, out, 1: the block accepts a word this cycle.
- `load_ovf`, out, 1: sticky flag; the load hit `DEPTH` before `load_last`.
- `prog_len`, out, clog2(`DEPTH`+1): number of words in the current valid program.
- `fetch_req`, in, 1: fetch request.
- `fetch_addr`, in, `ADDR_W`: byte address of the fetch.
- `fetch_valid`, out, 1: response strobe, asserted one cycle after `fetch_req`.
- `fetch_data`, out, `WIDTH`: the instruction word.
- `fetch_fault`, out, 1: the fetch is invalid; `fetch_data` equals `NOP_WORD`.

## Operation
- State machine states: IDLE (no program), LOAD, RUN.
- Reset state values:
  - state IDLE, `prog_len` 0, write pointer 0.
  - `load_ready` 0, `load_ovf` 0.
  - `fetch_valid` 0, `fetch_fault` 0, `fetch_data` `NOP_WORD`.
  - RAM contents are not reset.
- Transitions:
  - IDLE or RUN, `load_start` asserted: go to LOAD; write pointer 0, `prog_len` 0, `load_ovf` cleared.
  - LOAD, `load_start` asserted again: restart the load (pointer 0); any word presented that cycle is discarded.
  - LOAD, handshake (`load_valid` and `load_ready`): write `load_data` to RAM at the pointer, then increment the pointer.
  - Handshake with `load_last`: go to RUN, `prog_len` = pointer + 1.
  - Handshake at pointer `DEPTH`-1 without `load_last`: go to RUN, `prog_len` = `DEPTH`, set `load_ovf`. Later words are not accepted.
- `load_ready` equals (state == LOAD) and not `load_start`.
- Fetch rules, evaluated in the request cycle. The fetch faults if any one of these holds:
  - state is not RUN,
  - `load_start` is asserted,
  - `fetch_addr[1:0]` is not 0,
  - the word index is at or above `prog_len`.
- A non-faulting fetch returns the RAM word at the word index.
- Writes happen only in LOAD and reads are served only in RUN, so there is no read/write collision.

## Timing
- Fetch latency is exactly 1 cycle. A request in cycle N gives `fetch_valid`, `fetch_data` and `fetch_fault` in cycle N+1.
- Without a request, `fetch_valid` is 0 and `fetch_data`/`fetch_fault` hold their last values.
- Back-to-back fetches are supported at one per cycle with no bubbles.
- Load throughput is one word per cycle while `load_valid` is held high.
- `prog_len` and the state update in the cycle after the final handshake. A fetch issued in that next cycle is already served from RUN.
- Reset asserted during LOAD or during a fetch:
  - the next cycle is IDLE with `prog_len` 0,
  - any pending `fetch_valid` is dropped (0).

## Structure
- Shared package `imem_pkg` holds:
  - the state enum (IDLE/LOAD/RUN),
  - a helper function for word index from byte address,
  - the default `NOP_WORD` constant.
- Sub-module `imem_array`: a simple dual-port RAM, `WIDTH`×`DEPTH`, with a synchronous write port and a synchronous registered read port. The top level holds the FSM, pointer, length, fault logic and output mux.

## Test plan
- Reset, then fetch address 0x0 → the next cycle has `fetch_valid`=1, `fetch_fault`=1, `fetch_data`=`NOP_WORD`; `prog_len`=0.
- Load 3 words: 0x268088, 0x268088, 0x268109, with `load_last` on the third → `prog_len`=3. Fetches of 0x0, 0x4 and 0x8 on consecutive cycles return those words with `fault`=0, one cycle after each request.
- With that program loaded, fetch 0xC (index 3) → fault=1. Fetch 0x6 (misaligned) → fault=1.
- Use `DEPTH`=4 and stream 6 words without `load_last` → exactly 4 handshakes accepted, then RUN with `load_ovf`=1 and `prog_len`=4. `load_ready` is 0 afterwards.
- During LOAD, deassert `load_valid` for 2 cycles, then pulse `load_start` → pointer restarts. The next 2 words (0x1, 0x2, last) give `prog_len`=2, and fetch 0x0 returns 0x1.
- Assert `rst_n`=0 mid-load for 1 cycle → next cycle is IDLE, `load_ready`=0, `prog_len`=0, and fetches fault.
